// File: rtl/cvxif_issue_arbiter_pkg.sv
// Shared constants and types for the CV-X-IF issue arbiter.
package cvxif_issue_arbiter_pkg;

  localparam int unsigned DefNrPorts = 2;
  localparam int unsigned DefIdWidth = 3;

  // Exception cause used for instructions the coprocessor refuses.
  localparam logic [5:0] ILLEGAL_INSTR = 6'd2;

  // Width of the port-index field that is prepended to the transaction id.
  function automatic int unsigned arb_pw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned CVXIF_ARB_PW = arb_pw(DefNrPorts);

  // Coprocessor-side transaction tag at the default port count / id width.
  typedef struct packed {
    logic [CVXIF_ARB_PW-1:0] port_idx;
    logic [DefIdWidth-1:0]   trans_id;
  } cvxif_arb_tag_t;

endpackage

// File: rtl/cvxif_issue_arbiter_if.sv
// Bundle of requester-side and coprocessor-side signals of the issue arbiter.
// Optional macro CVXIF_ARB_PERF_EN adds the per-port performance counter outputs.
interface cvxif_issue_arbiter_if
  import cvxif_issue_arbiter_pkg::*;
#(
  parameter int unsigned NrPorts   = 2,
  parameter int unsigned IdWidth   = 3,
  parameter int unsigned XlenWidth = 64
);
  localparam int unsigned PW = arb_pw(NrPorts);

  // requester side
  logic [NrPorts-1:0]              req_valid_i;
  logic [NrPorts-1:0]              req_ready_o;
  logic [NrPorts-1:0][31:0]        req_instr_i;
  logic [NrPorts-1:0][IdWidth-1:0] req_id_i;
  logic [NrPorts-1:0]              res_valid_o;
  logic [IdWidth-1:0]              res_id_o;
  logic [XlenWidth-1:0]            res_data_o;
  logic                            res_we_o;
  logic                            res_exc_o;
  logic [5:0]                      res_exccode_o;
  // coprocessor side
  logic                            x_issue_valid_o;
  logic                            x_issue_ready_i;
  logic                            x_issue_accept_i;
  logic [31:0]                     x_issue_instr_o;
  logic [PW+IdWidth-1:0]           x_issue_id_o;
  logic                            x_result_valid_i;
  logic [PW+IdWidth-1:0]           x_result_id_i;
  logic [XlenWidth-1:0]            x_result_data_i;
  logic                            x_result_we_i;
  logic                            x_result_exc_i;
  logic [5:0]                      x_result_exccode_i;
`ifdef CVXIF_ARB_PERF_EN
  logic [NrPorts-1:0][31:0]        perf_issue_o;
  logic [NrPorts-1:0][31:0]        perf_stall_o;
`endif

  // arbiter view
  modport slave (
`ifdef CVXIF_ARB_PERF_EN
    output perf_issue_o, perf_stall_o,
`endif
    input  req_valid_i, req_instr_i, req_id_i,
    output req_ready_o, res_valid_o, res_id_o, res_data_o, res_we_o, res_exc_o, res_exccode_o,
    output x_issue_valid_o, x_issue_instr_o, x_issue_id_o,
    input  x_issue_ready_i, x_issue_accept_i,
    input  x_result_valid_i, x_result_id_i, x_result_data_i, x_result_we_i, x_result_exc_i,
    input  x_result_exccode_i
  );

  // environment view (requesters + coprocessor)
  modport master (
`ifdef CVXIF_ARB_PERF_EN
    input  perf_issue_o, perf_stall_o,
`endif
    output req_valid_i, req_instr_i, req_id_i,
    input  req_ready_o, res_valid_o, res_id_o, res_data_o, res_we_o, res_exc_o, res_exccode_o,
    input  x_issue_valid_o, x_issue_instr_o, x_issue_id_o,
    output x_issue_ready_i, x_issue_accept_i,
    output x_result_valid_i, x_result_id_i, x_result_data_i, x_result_we_i, x_result_exc_i,
    output x_result_exccode_i
  );

endinterface

// File: rtl/cvxif_issue_arbiter_rr_arb_lock.sv
// Round-robin arbiter that freezes its grant while the downstream stalls.
// The pointer advances past the winner only when the handshake completes.
module cvxif_issue_arbiter_rr_arb_lock #(
  parameter int unsigned NrPorts = 2,
  parameter int unsigned PW      = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NrPorts-1:0] req_i,
  input  logic               ready_i,
  output logic               gnt_vld_o,
  output logic [PW-1:0]      gnt_idx_o
);

  logic [PW-1:0] rr_ptr_q;
  logic [PW-1:0] lock_idx_q;
  logic          locked_q;
  logic [PW-1:0] srch_idx;
  logic          srch_vld;

  // first requester found walking upward from rr_ptr, wrapping at NrPorts
  always_comb begin
    srch_vld = 1'b0;
    srch_idx = '0;
    for (int unsigned i = 0; i < NrPorts; i++) begin
      automatic int unsigned j    = (32'(rr_ptr_q) + i) % NrPorts;
      automatic logic [PW-1:0] cand = PW'(j);
      if (!srch_vld && req_i[cand]) begin
        srch_vld = 1'b1;
        srch_idx = cand;
      end
    end
  end

  // a held grant wins over the search, even if its port became ineligible
  assign gnt_vld_o = locked_q | srch_vld;
  assign gnt_idx_o = locked_q ? lock_idx_q : srch_idx;

  // lock on a stalled grant, rotate the pointer on completion
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      locked_q   <= 1'b0;
    end else if (gnt_vld_o) begin
      if (ready_i) begin
        rr_ptr_q <= (gnt_idx_o == PW'(NrPorts - 1)) ? '0 : gnt_idx_o + 1'b1;
        locked_q <= 1'b0;
      end else begin
        locked_q   <= 1'b1;
        lock_idx_q <= gnt_idx_o;
      end
    end
  end

endmodule

// File: rtl/cvxif_issue_arbiter.sv
// Shares one CV-X-IF coprocessor port between NrPorts issue requesters:
// round-robin issue with stable grants, {port, id} tagging, per-port credit
// limit, result routing and synthesised illegal-instruction results.
// Optional macro CVXIF_ARB_PERF_EN adds per-port issue/stall counters.
module cvxif_issue_arbiter
  import cvxif_issue_arbiter_pkg::*;
#(
  parameter int unsigned NrPorts        = 2,
  parameter int unsigned IdWidth        = 3,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned XlenWidth      = 64
) (
  input logic                  clk_i,
  input logic                  rst_i,
  cvxif_issue_arbiter_if.slave bus
);

  localparam int unsigned PW = arb_pw(NrPorts);
  localparam int unsigned CW = $clog2(MaxOutstanding + 1);

  typedef struct packed {
    logic [PW-1:0]      port_idx;
    logic [IdWidth-1:0] trans_id;
  } tag_t;

  logic [NrPorts-1:0][CW-1:0]      credit_q;
  logic [NrPorts-1:0]              pend_ill_q;
  logic [NrPorts-1:0][IdWidth-1:0] pend_id_q;

  logic [NrPorts-1:0] elig;
  logic [NrPorts-1:0] issue_acc;
  logic [NrPorts-1:0] uflow;
  logic               gnt_vld;
  logic [PW-1:0]      gnt_idx;
  logic               issue_vld;
  logic               hs;
  tag_t               res_tag;
  logic               cop_fire;
  logic               ill_any;
  logic [PW-1:0]      ill_idx;
  logic               ill_fire;

  // ---------------- issue side ----------------
  for (genvar p = 0; p < NrPorts; p++) begin : g_elig
    assign elig[p] = bus.req_valid_i[p] && (credit_q[p] < CW'(MaxOutstanding)) && !pend_ill_q[p];
  end

  cvxif_issue_arbiter_rr_arb_lock #(
    .NrPorts (NrPorts),
    .PW      (PW)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (elig),
    .ready_i   (bus.x_issue_ready_i),
    .gnt_vld_o (gnt_vld),
    .gnt_idx_o (gnt_idx)
  );

  // outputs are forced quiet while reset is asserted
  assign issue_vld           = gnt_vld && !rst_i;
  assign hs                  = issue_vld && bus.x_issue_ready_i;
  assign bus.x_issue_valid_o = issue_vld;
  assign bus.x_issue_instr_o = issue_vld ? bus.req_instr_i[gnt_idx] : '0;
  assign bus.x_issue_id_o    = issue_vld ? {gnt_idx, bus.req_id_i[gnt_idx]} : '0;

  for (genvar p = 0; p < NrPorts; p++) begin : g_rdy
    assign bus.req_ready_o[p] = hs && (gnt_idx == PW'(p));
    assign issue_acc[p]       = bus.req_ready_o[p] && bus.x_issue_accept_i;
  end

  // ---------------- result side ----------------
  assign res_tag  = tag_t'(bus.x_result_id_i);
  // results tagged with a nonexistent port are dropped and leave the bus free
  assign cop_fire = bus.x_result_valid_i && (32'(res_tag.port_idx) < NrPorts) && !rst_i;

  // lowest-index pending illegal result gets the bus
  always_comb begin
    ill_any = 1'b0;
    ill_idx = '0;
    for (int i = int'(NrPorts) - 1; i >= 0; i--) begin
      if (pend_ill_q[i]) begin
        ill_any = 1'b1;
        ill_idx = PW'(i);
      end
    end
  end

  assign ill_fire = ill_any && !cop_fire && !rst_i;

  // shared result bus: coprocessor results pass through, illegal results fill idle cycles
  always_comb begin
    bus.res_valid_o   = '0;
    bus.res_id_o      = '0;
    bus.res_data_o    = '0;
    bus.res_we_o      = 1'b0;
    bus.res_exc_o     = 1'b0;
    bus.res_exccode_o = '0;
    if (cop_fire) begin
      bus.res_valid_o[res_tag.port_idx] = 1'b1;
      bus.res_id_o      = res_tag.trans_id;
      bus.res_data_o    = bus.x_result_data_i;
      bus.res_we_o      = bus.x_result_we_i;
      bus.res_exc_o     = bus.x_result_exc_i;
      bus.res_exccode_o = bus.x_result_exccode_i;
    end else if (ill_fire) begin
      bus.res_valid_o[ill_idx] = 1'b1;
      bus.res_id_o      = pend_id_q[ill_idx];
      bus.res_exc_o     = 1'b1;
      bus.res_exccode_o = ILLEGAL_INSTR;
    end
  end

  // ---------------- per-port state ----------------
  for (genvar p = 0; p < NrPorts; p++) begin : g_port
    logic dec;
    logic rej;
    logic clr;

    assign dec      = cop_fire && (res_tag.port_idx == PW'(p));
    assign rej      = bus.req_ready_o[p] && !bus.x_issue_accept_i;
    assign clr      = ill_fire && (ill_idx == PW'(p));
    assign uflow[p] = dec && (credit_q[p] == '0);

    // outstanding credits: +1 on accepted issue, -1 on result, saturating at 0
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        credit_q[p] <= '0;
      end else if (issue_acc[p] && !dec) begin
        credit_q[p] <= credit_q[p] + 1'b1;
      end else if (!issue_acc[p] && dec && (credit_q[p] != '0)) begin
        credit_q[p] <= credit_q[p] - 1'b1;
      end
    end

    // remember a rejected issue until its illegal result is sent
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        pend_ill_q[p] <= 1'b0;
        pend_id_q[p]  <= '0;
      end else if (rej) begin
        pend_ill_q[p] <= 1'b1;
        pend_id_q[p]  <= bus.req_id_i[p];
      end else if (clr) begin
        pend_ill_q[p] <= 1'b0;
      end
    end
  end

  // a result for a port with no outstanding transaction means a broken coprocessor
  a_no_uflow : assert property (@(posedge clk_i) disable iff (rst_i) uflow == '0)
    else $error("cvxif_issue_arbiter: credit underflow");

`ifdef CVXIF_ARB_PERF_EN
  for (genvar p = 0; p < NrPorts; p++) begin : g_perf
    logic [31:0] issue_cnt_q;
    logic [31:0] stall_cnt_q;

    // wrapping counters of accepted issues and cycles spent waiting for a grant
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        issue_cnt_q <= '0;
        stall_cnt_q <= '0;
      end else begin
        if (issue_acc[p]) issue_cnt_q <= issue_cnt_q + 32'd1;
        if (bus.req_valid_i[p] && !bus.req_ready_o[p]) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end

    assign bus.perf_issue_o[p] = issue_cnt_q;
    assign bus.perf_stall_o[p] = stall_cnt_q;
  end
`endif

endmodule

// File: tb/tb_cvxif_issue_arbiter.sv
// Directed bench for cvxif_issue_arbiter with a result scoreboard.
module tb_cvxif_issue_arbiter;
  import cvxif_issue_arbiter_pkg::*;

  localparam int unsigned NP = 2;
  localparam int unsigned IW = 3;
  localparam int unsigned MO = 4;
  localparam int unsigned XW = 64;

  typedef struct packed {
    logic [NP-1:0] vld;
    logic [IW-1:0] id;
    logic [XW-1:0] data;
    logic          we;
    logic          exc;
    logic [5:0]    code;
  } res_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  cvxif_issue_arbiter_if #(.NrPorts(NP), .IdWidth(IW), .XlenWidth(XW)) bus ();

  cvxif_issue_arbiter #(
    .NrPorts(NP), .IdWidth(IW), .MaxOutstanding(MO), .XlenWidth(XW)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  res_t sb[$];
  res_t mon_o, mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // every result on the shared bus must match the oldest expected entry
  always @(negedge clk_i) begin
    if (!rst_i && bus.res_valid_o != '0) begin
      mon_o = {bus.res_valid_o, bus.res_id_o, bus.res_data_o, bus.res_we_o, bus.res_exc_o,
               bus.res_exccode_o};
      if (sb.size() == 0) begin
        chk("unexpected_result", mon_o, '0);
      end else begin
        mon_e = sb.pop_front();
        chk("result", mon_o, mon_e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.req_valid_i        = '0;
    bus.x_issue_ready_i    = 1'b0;
    bus.x_issue_accept_i   = 1'b0;
    bus.x_result_valid_i   = 1'b0;
    bus.x_result_id_i      = '0;
    bus.x_result_data_i    = '0;
    bus.x_result_we_i      = 1'b0;
    bus.x_result_exc_i     = 1'b0;
    bus.x_result_exccode_i = '0;
  endtask

  // check one cycle of issue/result behaviour, then advance
  task automatic cyc(input string tag, input logic ev, input cvxif_arb_tag_t eid,
                     input logic [NP-1:0] erdy, input logic [31:0] einstr,
                     input logic [NP-1:0] eres);
    @(negedge clk_i);
    chk({tag, "_vld"}, bus.x_issue_valid_o, ev);
    if (ev) begin
      chk({tag, "_id"}, bus.x_issue_id_o, eid);
      chk({tag, "_instr"}, bus.x_issue_instr_o, einstr);
    end
    chk({tag, "_rdy"}, bus.req_ready_o, erdy);
    chk({tag, "_res"}, bus.res_valid_o, eres);
    tick();
  endtask

  task automatic cop_drive(input int port, input logic [IW-1:0] id, input logic [XW-1:0] d);
    cvxif_arb_tag_t t;
    res_t e;
    t.port_idx = port[CVXIF_ARB_PW-1:0];
    t.trans_id = id;
    bus.x_result_valid_i   = 1'b1;
    bus.x_result_id_i      = t;
    bus.x_result_data_i    = d;
    bus.x_result_we_i      = 1'b1;
    bus.x_result_exc_i     = 1'b0;
    bus.x_result_exccode_i = '0;
    e = '0;
    e.vld[port] = 1'b1;
    e.id   = id;
    e.data = d;
    e.we   = 1'b1;
    sb.push_back(e);
  endtask

  task automatic push_ill(input int port, input logic [IW-1:0] id);
    res_t e;
    e = '0;
    e.vld[port] = 1'b1;
    e.id   = id;
    e.exc  = 1'b1;
    e.code = 6'd2;
    sb.push_back(e);
  endtask

  task automatic ret(input int port, input logic [IW-1:0] id, input logic [XW-1:0] d);
    cop_drive(port, id, d);
    @(negedge clk_i);
    tick();
    bus.x_result_valid_i = 1'b0;
  endtask

  initial begin
    idle();
    bus.req_instr_i = '0;
    bus.req_id_i    = '0;
    // reset: outputs stay quiet even with requests and ready present
    bus.req_valid_i     = 2'b11;
    bus.x_issue_ready_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_issue_vld", bus.x_issue_valid_o, 1'b0);
    chk("rst_issue_id", bus.x_issue_id_o, '0);
    chk("rst_req_rdy", bus.req_ready_o, '0);
    chk("rst_res_vld", bus.res_valid_o, '0);
    chk("rst_res_exc", bus.res_exc_o, 1'b0);
    idle();
    tick();
    rst_i = 1'b0;

    // 1: alternating grants with both ports requesting
    bus.req_id_i[0] = 3'd1;  bus.req_instr_i[0] = 32'h0000_0A0B;
    bus.req_id_i[1] = 3'd6;  bus.req_instr_i[1] = 32'h0000_0C0D;
    bus.req_valid_i = 2'b11; bus.x_issue_ready_i = 1'b1; bus.x_issue_accept_i = 1'b1;
    for (int k = 0; k < 4; k++)
      cyc($sformatf("t1_g%0d", k), 1'b1, (k % 2) ? 4'b1110 : 4'b0001,
          (k % 2) ? 2'b10 : 2'b01, (k % 2) ? 32'h0000_0C0D : 32'h0000_0A0B, 2'b00);
    bus.req_valid_i = '0;
    ret(0, 3'd1, 64'h11); ret(1, 3'd6, 64'h22); ret(0, 3'd1, 64'h33); ret(1, 3'd6, 64'h44);

    // 2: stalled grant held on port 1 even after port 0 requests
    bus.req_valid_i = 2'b10; bus.x_issue_ready_i = 1'b0;
    for (int k = 0; k < 3; k++)
      cyc("t2_lock", 1'b1, 4'b1110, 2'b00, 32'h0000_0C0D, 2'b00);
    bus.req_valid_i = 2'b11;
    cyc("t2_hold", 1'b1, 4'b1110, 2'b00, 32'h0000_0C0D, 2'b00);
    bus.x_issue_ready_i = 1'b1;
    cyc("t2_fire", 1'b1, 4'b1110, 2'b10, 32'h0000_0C0D, 2'b00);
    cyc("t2_next", 1'b1, 4'b0001, 2'b01, 32'h0000_0A0B, 2'b00);
    bus.req_valid_i = '0;
    ret(1, 3'd6, 64'h55); ret(0, 3'd1, 64'h66);

    // 3: credit limit masks port 0, port 1 still served, one result reopens port 0
    bus.req_valid_i = 2'b01;
    for (int k = 0; k < MO; k++)
      cyc("t3_fill", 1'b1, 4'b0001, 2'b01, 32'h0000_0A0B, 2'b00);
    bus.req_valid_i = 2'b11;
    cyc("t3_full_p1", 1'b1, 4'b1110, 2'b10, 32'h0000_0C0D, 2'b00);
    bus.req_valid_i = 2'b01;
    cop_drive(0, 3'd1, 64'h77);
    cyc("t3_stall", 1'b0, 4'b0000, 2'b00, 32'h0, 2'b01);
    bus.x_result_valid_i = 1'b0;
    cyc("t3_regrant", 1'b1, 4'b0001, 2'b01, 32'h0000_0A0B, 2'b00);
    bus.req_valid_i = '0;
    for (int k = 0; k < MO; k++) ret(0, 3'd1, 64'h80 + 64'(k));
    ret(1, 3'd6, 64'h99);

    // 4: rejected issue yields an illegal result and leaves port 1 credits untouched
    bus.req_id_i[1] = 3'd5; bus.req_instr_i[1] = 32'hDEAD_BEEF;
    bus.req_valid_i = 2'b10; bus.x_issue_accept_i = 1'b0;
    cyc("t4_rej", 1'b1, 4'b1101, 2'b10, 32'hDEAD_BEEF, 2'b00);
    push_ill(1, 3'd5);
    bus.req_id_i[1] = 3'd2; bus.x_issue_accept_i = 1'b1;
    cyc("t4_masked", 1'b0, 4'b0000, 2'b00, 32'h0, 2'b10);
    for (int k = 0; k < MO; k++)
      cyc("t4_cred", 1'b1, 4'b1010, 2'b10, 32'hDEAD_BEEF, 2'b00);
    cyc("t4_full", 1'b0, 4'b0000, 2'b00, 32'h0, 2'b00);
    bus.req_valid_i = '0;
    for (int k = 0; k < MO; k++) ret(1, 3'd2, 64'hA0 + 64'(k));

    // 5: coprocessor result wins the bus over a pending illegal result
    bus.req_id_i[0] = 3'd3; bus.req_valid_i = 2'b01;
    cyc("t5_p0", 1'b1, 4'b0011, 2'b01, 32'h0000_0A0B, 2'b00);
    bus.req_id_i[1] = 3'd4; bus.req_valid_i = 2'b10; bus.x_issue_accept_i = 1'b0;
    cyc("t5_rej", 1'b1, 4'b1100, 2'b10, 32'hDEAD_BEEF, 2'b00);
    bus.req_valid_i = '0; bus.x_issue_accept_i = 1'b1;
    cop_drive(0, 3'd3, 64'h1234);
    push_ill(1, 3'd4);
    cyc("t5_cop", 1'b0, 4'b0000, 2'b00, 32'h0, 2'b01);
    bus.x_result_valid_i = 1'b0;
    cyc("t5_ill", 1'b0, 4'b0000, 2'b00, 32'h0, 2'b10);

    // 6: reset while locked with port 0 holding credits
    bus.req_valid_i = 2'b01;
    cyc("t6_a", 1'b1, 4'b0011, 2'b01, 32'h0000_0A0B, 2'b00);
    cyc("t6_b", 1'b1, 4'b0011, 2'b01, 32'h0000_0A0B, 2'b00);
    bus.req_valid_i = 2'b10; bus.x_issue_ready_i = 1'b0;
    cyc("t6_lock", 1'b1, 4'b1100, 2'b00, 32'hDEAD_BEEF, 2'b00);
    bus.req_valid_i = 2'b11;
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("t6_rst_vld", bus.x_issue_valid_o, 1'b0);
    chk("t6_rst_id", bus.x_issue_id_o, '0);
    chk("t6_rst_instr", bus.x_issue_instr_o, '0);
    chk("t6_rst_rdy", bus.req_ready_o, '0);
    chk("t6_rst_res", bus.res_valid_o, '0);
    tick();
    rst_i = 1'b0; bus.x_issue_ready_i = 1'b1;
    cyc("t6_after", 1'b1, 4'b0011, 2'b01, 32'h0000_0A0B, 2'b00);
    bus.req_valid_i = 2'b01;
    for (int k = 1; k < MO; k++)
      cyc("t6_cred", 1'b1, 4'b0011, 2'b01, 32'h0000_0A0B, 2'b00);
    cyc("t6_cred_full", 1'b0, 4'b0000, 2'b00, 32'h0, 2'b00);

    idle();
    repeat (3) tick();
    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
